// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and mux/ALU codes.
// MULTICYCLE_ADDI_EN adds the addi states and makes opcode 001000 legal.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXECUTE  = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
      OP_ADDI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-control decode for multicycle_ctrl (Moore, with FETCH writes gated by mem_ready).
// MULTICYCLE_ADDI_EN enables the ADDI_EX/ADDI_WB decode entries.
module ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ior_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o
);

  // Control decode per state; anything not set below stays 0
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ior_d_o         = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCS_ALU;
    illegal_o       = 1'b0;
    case (state_t'(state_i))
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: begin
        alu_src_b_o = SRCB_BOFS;
        illegal_o   = ~opcode_legal(opcode_i);
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        ior_d_o    = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        ior_d_o     = 1'b1;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCS_ALUOUT;
      end
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCS_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDI_EX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ADDI_WB: begin
        reg_write_o = 1'b1;
      end
`endif
      default: begin
        illegal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: state register, next-state logic, reset gating of all outputs.
// MULTICYCLE_ADDI_EN adds the DECODE -> ADDI_EX -> ADDI_WB -> FETCH path for opcode 001000.
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ior_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic       pc_write_s, pc_write_cond_s, ior_d_s, mem_read_s, mem_write_s, ir_write_s;
  logic       mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s, illegal_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

  // Next-state selection; unused codes fall through to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = ADDI_EX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if (opcode_i == OP_SW) begin
          state_d = MEM_WR;
        end else if (opcode_i == OP_LW) begin
          state_d = MEM_RD;
        end else begin
          state_d = FETCH;
        end
      end
      MEM_RD:   state_d = mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   state_d = mem_ready_i ? FETCH : MEM_WR;
      EXECUTE:  state_d = R_WB;
      R_WB:     state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
`ifdef MULTICYCLE_ADDI_EN
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  ctrl_decode u_decode (
    .state_i         (state_q),
    .opcode_i        (opcode_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_s),
    .pc_write_cond_o (pc_write_cond_s),
    .ior_d_o         (ior_d_s),
    .mem_read_o      (mem_read_s),
    .mem_write_o     (mem_write_s),
    .ir_write_o      (ir_write_s),
    .mem_to_reg_o    (mem_to_reg_s),
    .reg_dst_o       (reg_dst_s),
    .reg_write_o     (reg_write_s),
    .alu_src_a_o     (alu_src_a_s),
    .alu_src_b_o     (alu_src_b_s),
    .alu_op_o        (alu_op_s),
    .pc_source_o     (pc_source_s),
    .illegal_o       (illegal_s)
  );

  // Outputs are held at 0 for as long as reset is asserted, not just after the edge
  always_comb begin
    if (!rst_n_i) begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      ior_d_o         = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 2'b00;
      pc_source_o     = 2'b00;
      illegal_o       = 1'b0;
      state_o         = 4'd0;
    end else begin
      pc_write_o      = pc_write_s;
      pc_write_cond_o = pc_write_cond_s;
      ior_d_o         = ior_d_s;
      mem_read_o      = mem_read_s;
      mem_write_o     = mem_write_s;
      ir_write_o      = ir_write_s;
      mem_to_reg_o    = mem_to_reg_s;
      reg_dst_o       = reg_dst_s;
      reg_write_o     = reg_write_s;
      alu_src_a_o     = alu_src_a_s;
      alu_src_b_o     = alu_src_b_s;
      alu_op_o        = alu_op_s;
      pc_source_o     = pc_source_s;
      illegal_o       = illegal_s;
      state_o         = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table, reset corner case, random traffic.
// Honours MULTICYCLE_ADDI_EN so the same bench covers both builds.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .ior_d_o(ior_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .illegal_o(illegal), .state_o(state)
  );

  typedef struct packed {
    logic [5:0]      op;
    logic [3:0]      len;
    logic [9:0][3:0] seq;
  } vec_t;

  // Expected control word from the per-state control table:
  // {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal}
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, aop, pcs;
    logic legal;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = 11'd0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010);
`ifdef MULTICYCLE_ADDI_EN
    legal = legal || (op == 6'b001000);
`endif
    case (st)
      0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin sb = 2'b11; ill = ~legal; end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin sa = 1'b1; aop = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
      9:  begin pw = 1'b1; pcs = 2'b10; end
      10: begin sa = 1'b1; sb = 2'b10; end
      11: begin rw = 1'b1; end
      default: begin ill = 1'b0; end
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, ill};
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input int n,
                               input int s0 = 0, input int s1 = 0, input int s2 = 0, input int s3 = 0,
                               input int s4 = 0, input int s5 = 0, input int s6 = 0, input int s7 = 0);
    vec_t v;
    v.op = op;
    v.len = 4'(n);
    v.seq = '0;
    v.seq[0] = 4'(s0); v.seq[1] = 4'(s1); v.seq[2] = 4'(s2); v.seq[3] = 4'(s3);
    v.seq[4] = 4'(s4); v.seq[5] = 4'(s5); v.seq[6] = 4'(s6); v.seq[7] = 4'(s7);
    return v;
  endfunction

  task automatic chk(input string name, input int es, input logic [16:0] ec);
    logic [16:0] act;
    act = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
    vectors++;
    if (state !== 4'(es) || act !== ec) begin
      miscompares++;
      $display("FAIL %s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
               name, state, act, es, ec);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Path of states one instruction visits, FETCH first, wait states listed once
  int path[$];
  task automatic build_path(input logic [5:0] op);
    path = '{0, 1};
    case (op)
      6'b000000: path = '{0, 1, 6, 7};
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: path = '{0, 1, 10, 11};
`endif
      default:   path = '{0, 1};
    endcase
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mkv(6'b000000, 4, 0, 1, 6, 7);
    vecs[1]  = mkv(6'b100011, 8, 0, 1, 2, 3, 3, 3, 3, 4);
    vecs[2]  = mkv(6'b101011, 5, 0, 1, 2, 5, 5);
    vecs[3]  = mkv(6'b000100, 3, 0, 1, 8);
    vecs[4]  = mkv(6'b000010, 3, 0, 1, 9);
    vecs[5]  = mkv(6'b111111, 2, 0, 1);
`ifdef MULTICYCLE_ADDI_EN
    vecs[6]  = mkv(6'b001000, 4, 0, 1, 10, 11);
`else
    vecs[6]  = mkv(6'b001000, 2, 0, 1);
`endif
    vecs[7]  = mkv(6'b000000, 6, 0, 0, 0, 1, 6, 7);
    vecs[8]  = mkv(6'b100011, 5, 0, 1, 2, 3, 4);
    vecs[9]  = mkv(6'b101011, 4, 0, 1, 2, 5);
    vecs[10] = mkv(6'b010101, 2, 0, 1);

    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_hold", 0, 17'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_release", 0, exp_ctrl(0, 1'b0, opcode));
    step();

    // Directed table: a cell holds mem_ready low when the next cell repeats its state
    foreach (vecs[v]) begin
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        opcode = vecs[v].op;
        mem_ready = (i + 1 < int'(vecs[v].len) && vecs[v].seq[i + 1] == vecs[v].seq[i]) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk($sformatf("table%0d_c%0d", v, i), int'(vecs[v].seq[i]), exp_ctrl(int'(vecs[v].seq[i]), mem_ready, opcode));
        step();
      end
    end

    // Reset asserted while a store is waiting in MEM_WR
    opcode = 6'b101011; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_seq_fetch", 0, exp_ctrl(0, 1'b1, opcode));
    step();
    step();
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    chk("rst_seq_memwr", 5, exp_ctrl(5, 1'b0, opcode));
    rst_n = 1'b0;
    #1;
    chk("rst_seq_low0", 0, 17'd0);
    step();
    @(negedge clk);
    chk("rst_seq_low1", 0, 17'd0);
    step();
    @(negedge clk);
    chk("rst_seq_low2", 0, 17'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_seq_release", 0, exp_ctrl(0, 1'b0, opcode));
    step();

    // Random instruction stream with random memory stalls
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int idx, cyc;
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      build_path(op);
      idx = 0;
      cyc = 0;
      while (idx < path.size() && cyc < 60) begin
        opcode = op;
        mem_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        chk($sformatf("rand%0d_c%0d", n, cyc), path[idx], exp_ctrl(path[idx], mem_ready, op));
        if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mem_ready)) idx++;
        cyc++;
        step();
      end
      if (cyc >= 60) begin
        vectors++;
        miscompares++;
        $display("FAIL rand%0d_budget: got %0d cycles, required fewer than 60", n, cyc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The interface SHALL use one clock and a synchronous, active-low reset.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  reset, active low, sampled only on the CLK rising edge.
REQ-004 OPCODE  input  6  instruction-register bits [31:26], valid from DECODE onward.
REQ-005 MEM_READY  input  1  memory has completed the current access this cycle.
REQ-006 PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, IR_WRITE, MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A  output  1 each  datapath controls.
REQ-007 ALU_SRC_B, ALU_OP, PC_SOURCE  output  2 each  datapath mux and ALU controls.
REQ-008 ILLEGAL  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 STATE  output  4  current state code, for debug.

Function
REQ-010 The FSM SHALL use these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
REQ-011 All outputs SHALL be Moore outputs decoded from STATE, except where REQ-012 gates them with MEM_READY. Unlisted controls are 0.
REQ-012 FETCH controls:
- MEM_READ=1, IOR_D=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=00, PC_SOURCE=00.
- IR_WRITE and PC_WRITE = MEM_READY.
- The FSM stays in FETCH until MEM_READY=1, then goes to DECODE.
REQ-013 DECODE controls: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00. Next state by OPCODE:
- 000000 -> EXECUTE
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EX (REQ-024)
- any other -> FETCH, with ILLEGAL=1 for that cycle.
REQ-014 MEM_ADDR controls: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Next state is MEM_RD for lw, MEM_WR for sw.
REQ-015 MEM_RD controls: MEM_READ=1, IOR_D=1. The FSM holds until MEM_READY=1, then goes to MEM_WB.
REQ-016 MEM_WB controls: REG_DST=0 (rt), MEM_TO_REG=1, REG_WRITE=1. Next state is FETCH.
REQ-017 MEM_WR controls: MEM_WRITE=1, IOR_D=1. The FSM holds until MEM_READY=1, then goes to FETCH.
REQ-018 EXECUTE controls: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10. Next state is R_WB.
REQ-019 R_WB controls: REG_DST=1 (rd), MEM_TO_REG=0, REG_WRITE=1. Next state is FETCH.
REQ-020 BRANCH controls: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01, PC_WRITE_COND=1, PC_SOURCE=01. Next state is FETCH.
REQ-021 JUMP controls: PC_WRITE=1, PC_SOURCE=10. Next state is FETCH.
REQ-022 Instruction latency with MEM_READY tied to 1:
- 3 cycles: beq, j
- 4 cycles: R-type, sw
- 5 cycles: lw
- Each MEM_READY=0 cycle in a memory state adds one cycle.
REQ-023 REG_WRITE and MEM_WRITE SHALL never be 1 in the same cycle, and REG_WRITE SHALL be 1 only in a *_WB state.

Reset
REQ-030 RST_N=0 at a rising CLK edge SHALL force STATE to FETCH, whatever the current state, including mid-wait in MEM_RD or MEM_WR.
REQ-031 While RST_N=0, all outputs SHALL be forced to 0: PC_WRITE, PC_WRITE_COND, MEM_READ, MEM_WRITE, IR_WRITE, REG_WRITE and ILLEGAL, and all mux selects.
REQ-032 The first cycle after RST_N returns high SHALL be FETCH with MEM_READ=1.

Configuration
REQ-024 Macro MULTICYCLE_ADDI_EN:
- Defined: opcode 001000 goes DECODE -> ADDI_EX -> ADDI_WB -> FETCH.
- ADDI_EX controls: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00.
- ADDI_WB controls: REG_DST=0, MEM_TO_REG=0, REG_WRITE=1.
- Undefined: states 10/11 are absent and 001000 is handled as illegal (REQ-013).
REQ-025 Any unreachable or unused state code SHALL recover to FETCH on the next edge.

Structure
REQ-040 Package multicycle_pkg SHALL hold the state encodings, opcode constants, and ALU_OP and PC_SOURCE codes.
REQ-041 Combinational state-to-control decode SHALL be a sub-module, ctrl_decode. Next-state logic and the state register stay in multicycle_ctrl.

Verification
REQ-050 Reset: RST_N=0 for 2 cycles in state MEM_WR -> STATE=0 and all outputs 0; after release, STATE=0 and MEM_READ=1.
REQ-051 R-type: OPCODE=000000, MEM_READY=1 -> STATE sequence 0,1,6,7,0; REG_DST=1 and REG_WRITE=1 only in state 7.
REQ-052 lw with stall: OPCODE=100011, MEM_READY=0 for 3 cycles in MEM_RD -> STATE 0,1,2,3,3,3,3,4,0; REG_DST=0 in state 4.
REQ-053 beq/j: OPCODE=000100 -> 0,1,8,0 with PC_WRITE_COND=1 in 8; OPCODE=000010 -> 0,1,9,0 with PC_SOURCE=10.
REQ-054 Illegal opcode OPCODE=111111 -> ILLEGAL=1 for exactly one cycle in DECODE, no REG_WRITE/MEM_WRITE, next STATE=0.
REQ-055 addi: OPCODE=001000 gives 0,1,10,11,0 with MULTICYCLE_ADDI_EN defined, and an ILLEGAL pulse without it.
